cipher_demux: RTL and testbench
===============================

Name: cipher_demux

Overview:
- Stream demultiplexer at the input side of the decryption datapath.
- Takes one character stream and routes each whole message to one of three decryptor inputs: 0 = Caesar, 1 = scytale, 2 = zigzag.
- The route is fixed per message: it is captured on the first character and released on the terminator character.
- Reports the length of each completed message and flags messages with an illegal route.

Parameters:
- D_WIDTH, 8, character width in bits.
- END_CHAR, 8'hFA, message terminator value; compared over the full D_WIDTH.
- LEN_WIDTH, 16, width of the message length counter.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- select  in  2  route request; sampled only on the first character of a message.
- data_i  in  D_WIDTH  input character.
- valid_i  in  1  data_i valid this cycle.
- data0_o  out  D_WIDTH  character to decryptor 0.
- valid0_o  out  1  data0_o valid.
- data1_o  out  D_WIDTH  character to decryptor 1.
- valid1_o  out  1  data1_o valid.
- data2_o  out  D_WIDTH  character to decryptor 2.
- valid2_o  out  1  data2_o valid.
- busy_o  out  1  high while a message is in progress (state != IDLE).
- msg_len_o  out  LEN_WIDTH  character count of the last completed message, terminator included.
- len_valid_o  out  1  one-cycle pulse when msg_len_o updates.
- err_o  out  1  one-cycle pulse when a message is captured with select==3.

Behaviour:
- Reset (rst=1 at posedge):
  - all outputs go to 0 and state goes to IDLE.
  - Internal count, latched route and drop counter go to 0.
  - Reset mid-message aborts the message: no len_valid_o pulse; the next valid_i starts a new message.
- All outputs are registered. Latency is 1 cycle from valid_i to validN_o, err_o, len_valid_o and busy_o.
- No backpressure: valid_i is accepted every cycle it is high.
- validN_o is high for exactly one N per accepted routed character; the other two valids are 0.
- dataN_o updates only when validN_o is asserted and holds its last value otherwise.
- FSM states: IDLE, ROUTE, DROP.
- IDLE, valid_i=0: no output activity.
- IDLE, valid_i=1:
  - Latch sel_q=select and set count=1.
  - If select<3: forward the character to output sel_q.
    - If data_i==END_CHAR: pulse len_valid_o with msg_len_o=1 and stay in IDLE.
    - Else go to ROUTE.
  - If select==3: pulse err_o and do not forward.
    - If data_i==END_CHAR: stay in IDLE, no len pulse.
    - Else go to DROP.
- ROUTE, valid_i=1:
  - Forward to sel_q; changes on select are ignored.
  - count increments and saturates at all-ones.
  - If data_i==END_CHAR: msg_len_o=count+1 (saturated), pulse len_valid_o, go to IDLE.
- ROUTE, valid_i=0: hold state and count; no outputs.
- DROP: characters are discarded until END_CHAR, then go to IDLE. No len pulse; err_o is not repeated.
- busy_o is registered: 1 in the cycle after the first character of a multi-character message, and 0 in the cycle after END_CHAR is accepted.
- Back-to-back messages: END_CHAR followed in the very next cycle by a new character starts a new message with a fresh select capture. There is no idle gap requirement.

Optional Feature:
- Macro DEMUX_DROP_CNT_EN.
- Defined: adds port drop_cnt_o (out, 16 bits). It increments once per character discarded in DROP state or on a select==3 capture, saturates at 16'hFFFF, and is cleared only by rst.
- Not defined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- rst=1 for 2 cycles -> every output is 0 and busy_o=0.
- select=1; send 'A','B',8'hFA on consecutive cycles -> valid1_o high for 3 cycles with data 'A','B',8'hFA, each one cycle after its input; valid0_o and valid2_o stay 0; len_valid_o pulses with msg_len_o=3.
- select=2 at the first character, then switch select to 0 mid-message; send 5 chars ending in 8'hFA with 2 idle gaps -> all 5 characters appear on data2_o only; msg_len_o=5.
- select=3; send 'X','Y',8'hFA -> err_o pulses once; no validN_o; no len_valid_o. With DEMUX_DROP_CNT_EN defined, drop_cnt_o=3.
- Send 8'hFA alone with select=0, then 'Q',8'hFA with select=2 on the next cycles -> msg_len_o=1 on output 0, then msg_len_o=2 on output 2; the select capture is fresh for the second message.
- select=1; send 'A','B', assert rst, release it, then send select=0 with 'C',8'hFA -> no len pulse for the aborted message; 'C' and 8'hFA appear on data0_o; msg_len_o=2.

Source files
------------

// File: rtl/cipher_demux_if.sv
// cipher_demux_if: bus between the character source and the cipher
// demultiplexer.
//   master modport : character source (drives select/data_i/valid_i,
//                    observes the three routed streams and status)
//   slave modport  : cipher_demux itself
// Signals:
//   select, data_i, valid_i          : input character stream and route request
//   data0_o..data2_o, valid0_o..2_o  : routed character streams
//   busy_o, msg_len_o, len_valid_o   : message status and completed length
//   err_o                            : illegal-route pulse
//   drop_cnt_o                       : discarded character count, present only
//                                      when DEMUX_DROP_CNT_EN is defined
interface cipher_demux_if #(
  parameter int D_WIDTH   = 8,
  parameter int LEN_WIDTH = 16
);
  logic [1:0]           select;
  logic [D_WIDTH-1:0]   data_i;
  logic                 valid_i;
  logic [D_WIDTH-1:0]   data0_o;
  logic                 valid0_o;
  logic [D_WIDTH-1:0]   data1_o;
  logic                 valid1_o;
  logic [D_WIDTH-1:0]   data2_o;
  logic                 valid2_o;
  logic                 busy_o;
  logic [LEN_WIDTH-1:0] msg_len_o;
  logic                 len_valid_o;
  logic                 err_o;
`ifdef DEMUX_DROP_CNT_EN
  logic [15:0]          drop_cnt_o;
`endif

  modport master (
    output select, data_i, valid_i,
    input  data0_o, valid0_o, data1_o, valid1_o, data2_o, valid2_o,
    input  busy_o, msg_len_o, len_valid_o, err_o
`ifdef DEMUX_DROP_CNT_EN
    , input drop_cnt_o
`endif
  );

  modport slave (
    input  select, data_i, valid_i,
    output data0_o, valid0_o, data1_o, valid1_o, data2_o, valid2_o,
    output busy_o, msg_len_o, len_valid_o, err_o
`ifdef DEMUX_DROP_CNT_EN
    , output drop_cnt_o
`endif
  );
endinterface

// File: rtl/cipher_demux.sv
// cipher_demux: routes whole messages of a character stream to one of three
// decryptors (0 = Caesar, 1 = scytale, 2 = zigzag). The route is captured on
// the first character of a message and held until the terminator END_CHAR.
// Messages requesting route 3 are flagged on err_o and discarded.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous reset, active-high
//   bus  : cipher_demux_if.slave (input stream, three routed outputs, status)
// Optional feature: define DEMUX_DROP_CNT_EN to add bus.drop_cnt_o, a
// saturating 16-bit count of discarded characters cleared only by rst.
// All outputs are registered; latency from valid_i is one cycle.
module cipher_demux #(
  parameter int                 D_WIDTH   = 8,
  parameter logic [D_WIDTH-1:0] END_CHAR  = 8'hFA,
  parameter int                 LEN_WIDTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  cipher_demux_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ROUTE, DROP} state_t;

  state_t               state;
  logic [1:0]           sel_q;
  logic [LEN_WIDTH-1:0] count;

  logic                 is_end;
  logic                 fwd_en;
  logic [1:0]           fwd_route;
  logic [LEN_WIDTH-1:0] count_next;

  function automatic logic [LEN_WIDTH-1:0] sat_inc_len(input logic [LEN_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // The first character of a message uses the live select; later characters
  // use the latched route so mid-message select changes are ignored.
  always_comb begin
    is_end     = (bus.data_i == END_CHAR);
    fwd_route  = (state == IDLE) ? bus.select : sel_q;
    fwd_en     = bus.valid_i &&
                 (((state == IDLE) && (bus.select != 2'd3)) || (state == ROUTE));
    count_next = sat_inc_len(count);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      sel_q           <= '0;
      count           <= '0;
      bus.data0_o     <= '0;
      bus.data1_o     <= '0;
      bus.data2_o     <= '0;
      bus.valid0_o    <= 1'b0;
      bus.valid1_o    <= 1'b0;
      bus.valid2_o    <= 1'b0;
      bus.busy_o      <= 1'b0;
      bus.msg_len_o   <= '0;
      bus.len_valid_o <= 1'b0;
      bus.err_o       <= 1'b0;
    end else begin
      bus.valid0_o    <= 1'b0;
      bus.valid1_o    <= 1'b0;
      bus.valid2_o    <= 1'b0;
      bus.len_valid_o <= 1'b0;
      bus.err_o       <= 1'b0;

      if (fwd_en) begin
        case (fwd_route)
          2'd0: begin bus.data0_o <= bus.data_i; bus.valid0_o <= 1'b1; end
          2'd1: begin bus.data1_o <= bus.data_i; bus.valid1_o <= 1'b1; end
          2'd2: begin bus.data2_o <= bus.data_i; bus.valid2_o <= 1'b1; end
          default: ;
        endcase
      end

      case (state)
        IDLE: begin
          if (bus.valid_i) begin
            sel_q <= bus.select;
            count <= LEN_WIDTH'(1);
            if (bus.select != 2'd3) begin
              if (is_end) begin
                // single-character message: complete immediately
                bus.msg_len_o   <= LEN_WIDTH'(1);
                bus.len_valid_o <= 1'b1;
                bus.busy_o      <= 1'b0;
              end else begin
                state      <= ROUTE;
                bus.busy_o <= 1'b1;
              end
            end else begin
              bus.err_o <= 1'b1;
              if (is_end) begin
                bus.busy_o <= 1'b0;
              end else begin
                state      <= DROP;
                bus.busy_o <= 1'b1;
              end
            end
          end
        end
        ROUTE: begin
          if (bus.valid_i) begin
            count <= count_next;
            if (is_end) begin
              bus.msg_len_o   <= count_next;
              bus.len_valid_o <= 1'b1;
              state           <= IDLE;
              bus.busy_o      <= 1'b0;
            end
          end
        end
        DROP: begin
          if (bus.valid_i && is_end) begin
            state      <= IDLE;
            bus.busy_o <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          bus.busy_o <= 1'b0;
        end
      endcase
    end
  end

`ifdef DEMUX_DROP_CNT_EN
  logic drop_en;

  function automatic logic [15:0] sat_inc_drop(input logic [15:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Counts the illegal-route capture character and every character
  // discarded afterwards, terminator included.
  assign drop_en = bus.valid_i &&
                   (((state == IDLE) && (bus.select == 2'd3)) || (state == DROP));

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.drop_cnt_o <= '0;
    end else if (drop_en) begin
      bus.drop_cnt_o <= sat_inc_drop(bus.drop_cnt_o);
    end
  end
`endif

endmodule

// File: tb/tb_cipher_demux.sv
module tb_cipher_demux;

  localparam logic [7:0] END = 8'hFA;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  cipher_demux_if #(.D_WIDTH(8), .LEN_WIDTH(16)) bus ();

  cipher_demux #(.D_WIDTH(8), .END_CHAR(8'hFA), .LEN_WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Message-level reference model: a message is "open" from its first
  // character until the terminator; its destination is fixed at opening.
  bit        m_open;
  int        m_dest;
  int        m_len;
  logic [7:0] e_data [3];
  bit        e_valid [3];
  bit        e_busy, e_len_valid, e_err;
  int        e_msg_len;
  int        e_drops;

  task automatic model_reset();
    m_open = 0; m_dest = 0; m_len = 0;
    for (int i = 0; i < 3; i++) begin e_data[i] = 8'h00; e_valid[i] = 0; end
    e_busy = 0; e_len_valid = 0; e_err = 0; e_msg_len = 0; e_drops = 0;
  endtask

  task automatic model_accept(input logic [1:0] s, input bit v, input logic [7:0] d);
    for (int i = 0; i < 3; i++) e_valid[i] = 0;
    e_len_valid = 0;
    e_err = 0;
    if (v) begin
      if (!m_open) begin
        m_open = 1; m_dest = int'(s); m_len = 0;
        if (m_dest == 3) e_err = 1;
      end
      if (m_len < 65535) m_len++;
      if (m_dest < 3) begin
        e_valid[m_dest] = 1;
        e_data[m_dest]  = d;
      end else if (e_drops < 65535) begin
        e_drops++;
      end
      if (d == END) begin
        m_open = 0;
        if (m_dest < 3) begin
          e_len_valid = 1;
          e_msg_len   = m_len;
        end
      end
    end
    e_busy = m_open;
  endtask

  task automatic compare_all();
    check_eq("valid0", bus.valid0_o, e_valid[0]);
    check_eq("valid1", bus.valid1_o, e_valid[1]);
    check_eq("valid2", bus.valid2_o, e_valid[2]);
    check_eq("data0", bus.data0_o, e_data[0]);
    check_eq("data1", bus.data1_o, e_data[1]);
    check_eq("data2", bus.data2_o, e_data[2]);
    check_eq("busy", bus.busy_o, e_busy);
    check_eq("len_valid", bus.len_valid_o, e_len_valid);
    check_eq("msg_len", bus.msg_len_o, e_msg_len);
    check_eq("err", bus.err_o, e_err);
`ifdef DEMUX_DROP_CNT_EN
    check_eq("drop_cnt", bus.drop_cnt_o, e_drops);
`endif
  endtask

  task automatic step(input logic [1:0] s, input bit v, input logic [7:0] d);
    rst         = 1'b0;
    bus.select  = s;
    bus.valid_i = v;
    bus.data_i  = d;
    @(posedge clk);
    model_accept(s, v, d);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    bus.valid_i = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    compare_all();
  endtask

  int rv;
  logic [7:0] rd;

  initial begin
    bus.select  = 2'd0;
    bus.valid_i = 1'b0;
    bus.data_i  = 8'h00;
    model_reset();

    // reset held for two cycles
    do_reset();
    do_reset();
    check_eq("rst_busy", bus.busy_o, 0);

    // route 1, three characters
    step(2'd1, 1, "A");
    step(2'd1, 1, "B");
    step(2'd1, 1, END);
    check_eq("t1_len_valid", bus.len_valid_o, 1);
    check_eq("t1_len", bus.msg_len_o, 3);
    step(2'd0, 0, 8'h00);

    // route 2 captured, select changes mid-message, idle gaps
    step(2'd2, 1, 8'h11);
    step(2'd0, 1, 8'h22);
    step(2'd0, 0, 8'h00);
    step(2'd0, 1, 8'h33);
    step(2'd0, 0, 8'h00);
    step(2'd0, 1, 8'h44);
    step(2'd0, 1, END);
    check_eq("t2_valid2", bus.valid2_o, 1);
    check_eq("t2_len", bus.msg_len_o, 5);

    // illegal route 3
    step(2'd3, 1, "X");
    check_eq("t3_err", bus.err_o, 1);
    step(2'd3, 1, "Y");
    step(2'd3, 1, END);
    check_eq("t3_no_len", bus.len_valid_o, 0);
`ifdef DEMUX_DROP_CNT_EN
    check_eq("t3_drop_cnt", bus.drop_cnt_o, 3);
`endif

    // lone terminator, then back-to-back message with fresh capture
    step(2'd0, 1, END);
    check_eq("t4_len1", bus.msg_len_o, 1);
    check_eq("t4_valid0", bus.valid0_o, 1);
    step(2'd2, 1, "Q");
    step(2'd2, 1, END);
    check_eq("t4_len2", bus.msg_len_o, 2);
    check_eq("t4_valid2", bus.valid2_o, 1);

    // reset aborts a message in progress
    step(2'd1, 1, "A");
    step(2'd1, 1, "B");
    do_reset();
    step(2'd0, 1, "C");
    step(2'd0, 1, END);
    check_eq("t5_data0", bus.data0_o, END);
    check_eq("t5_len", bus.msg_len_o, 2);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rv = $urandom_range(0, 199);
      if (rv == 0) begin
        do_reset();
      end else begin
        rd = ($urandom_range(0, 5) == 0) ? END : 8'($urandom);
        step(2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0), rd);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
